// File: rtl/board_input_conditioner.sv
// Board button/switch conditioner: 2-flop sync, per-bit debounce, press/release pulses, core-select index.
// Optional auto-repeat on keys 0/1 when BOARD_INPUT_AUTO_REPEAT_EN is defined.
module board_input_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int NUM_CORES       = 8,
  parameter int ID_WIDTH        = 4,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n_in,
  input  logic [NUM_SW-1:0]   sw_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_level,
  output logic [31:0]         peek_address,
  output logic [ID_WIDTH-1:0] peek_id
);

  localparam int N = NUM_KEYS + NUM_SW;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0] KEY_MASK = {{NUM_SW{1'b0}}, {NUM_KEYS{1'b1}}};
  localparam logic [ID_WIDTH-1:0] ID_LAST = ID_WIDTH'(NUM_CORES - 1);

  logic [N-1:0]        sync1_q, sync2_q;
  logic [N-1:0]        level_q, level_d;
  logic [N-1:0]        synced;
  logic [CNT_W-1:0]    cnt_q [N];
  logic [CNT_W-1:0]    cnt_d [N];
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_release_q, key_release_d;
  logic [NUM_KEYS-1:0] key_rise, key_fall, rpt_fire;
  logic [ID_WIDTH-1:0] peek_id_q, peek_id_d;
  logic                id_inc, id_dec, id_clr;

  // Keys and switches share one sync/debounce path; keys are flipped to active-high after sync.
  assign synced = sync2_q ^ KEY_MASK;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (synced[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) level_d[i] = synced[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign key_rise = level_d[NUM_KEYS-1:0] & ~level_q[NUM_KEYS-1:0];
  assign key_fall = ~level_d[NUM_KEYS-1:0] & level_q[NUM_KEYS-1:0];

`ifdef BOARD_INPUT_AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  localparam int NUM_RPT = (NUM_KEYS < 2) ? NUM_KEYS : 2;

  logic [RPT_W-1:0] rpt_q [NUM_RPT];
  logic [RPT_W-1:0] rpt_d [NUM_RPT];

  // Counter only runs while the key is held and not being released this cycle.
  always_comb begin
    rpt_fire = '0;
    for (int k = 0; k < NUM_RPT; k++) begin
      rpt_d[k] = '0;
      if (level_q[k] && level_d[k]) begin
        if (rpt_q[k] == RPT_LAST) rpt_fire[k] = 1'b1;
        else                      rpt_d[k] = rpt_q[k] + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_RPT; k++) rpt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_RPT; k++) rpt_q[k] <= rpt_d[k];
    end
  end
`else
  logic [31:0] rpt_cycles_unused;
  assign rpt_cycles_unused = 32'(REPEAT_CYCLES);
  assign rpt_fire = '0;
`endif

  assign key_press_d   = key_rise | rpt_fire;
  assign key_release_d = key_fall;

  generate
    if (NUM_KEYS > 2) begin : g_clr
      assign id_clr = key_press_q[2];
    end else begin : g_no_clr
      assign id_clr = 1'b0;
    end
    if (NUM_KEYS > 1) begin : g_dec
      assign id_dec = key_press_q[1];
    end else begin : g_no_dec
      assign id_dec = 1'b0;
    end
    if (NUM_KEYS > 0) begin : g_inc
      assign id_inc = key_press_q[0];
    end else begin : g_no_inc
      assign id_inc = 1'b0;
    end
  endgenerate

  always_comb begin
    peek_id_d = peek_id_q;
    if (id_clr) begin
      peek_id_d = '0;
    end else if (id_inc && !id_dec) begin
      peek_id_d = (peek_id_q == ID_LAST) ? '0 : peek_id_q + ID_WIDTH'(1);
    end else if (id_dec && !id_inc) begin
      peek_id_d = (peek_id_q == '0) ? ID_LAST : peek_id_q - ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= KEY_MASK;
      sync2_q       <= KEY_MASK;
      level_q       <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      peek_id_q     <= '0;
    end else begin
      sync1_q       <= {sw_in, key_n_in};
      sync2_q       <= sync1_q;
      level_q       <= level_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      peek_id_q     <= peek_id_d;
    end
  end

  assign key_level    = level_q[NUM_KEYS-1:0];
  assign sw_level     = level_q[N-1:NUM_KEYS];
  assign key_press    = key_press_q;
  assign key_release  = key_release_q;
  assign peek_id      = peek_id_q;
  assign peek_address = 32'(sw_level);

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench for board_input_conditioner: stimulus queues expected output snapshots,
// a negedge monitor pops one whenever the visible outputs change.
module tb_board_input_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  key_n_in = 3'b111;
  logic [9:0]  sw_in = '0;
  logic [2:0]  key_level, key_press, key_release;
  logic [9:0]  sw_level;
  logic [31:0] peek_address;
  logic [3:0]  peek_id;

  board_input_conditioner #(
    .NUM_KEYS(3), .NUM_SW(10), .DEBOUNCE_CYCLES(4),
    .NUM_CORES(8), .ID_WIDTH(4), .REPEAT_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .key_n_in(key_n_in), .sw_in(sw_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .sw_level(sw_level), .peek_address(peek_address), .peek_id(peek_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [9:0] sw;
    logic [3:0] id;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic [9:0] cur_sw = '0;
  logic [3:0] cur_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: one scoreboard entry per change of the visible outputs.
  initial begin
    snap_t snap, prev;
    exp_t  e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        snap = {key_level, key_press, key_release, sw_level, peek_id};
        if (snap !== prev) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event cyc=%0d got=%h", cyc, snap);
          end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.s !== snap || peek_address !== {22'd0, e.s.sw}) begin
              fails++;
              $display("FAIL event got cyc=%0d snap=%h addr=%h want cyc=%0d snap=%h",
                       cyc, snap, peek_address, e.cyc, e.s);
            end
          end
          prev = snap;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [2:0] lvl, input logic [2:0] prs,
                      input logic [2:0] rel, input logic [9:0] sw, input logic [3:0] id);
    exp_t e;
    e.cyc = c;
    e.s   = {lvl, prs, rel, sw, id};
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic release_keys(input logic [2:0] m);
    int c0;
    c0 = cyc;
    key_n_in = 3'b111;
    push(c0 + 6, 3'b000, 3'b000, m, cur_sw, cur_id);
    push(c0 + 7, 3'b000, 3'b000, 3'b000, cur_sw, cur_id);
    tick(8);
  endtask

  // Press keys in m, hold past acceptance, then release; id_after is the expected peek_id.
  task automatic pr(input logic [2:0] m, input logic [3:0] id_after);
    int c0;
    c0 = cyc;
    key_n_in = ~m;
    push(c0 + 6, m, m, 3'b000, cur_sw, cur_id);
    push(c0 + 7, m, 3'b000, 3'b000, cur_sw, id_after);
    cur_id = id_after;
    tick(8);
    release_keys(m);
  endtask

  task automatic set_sw(input logic [9:0] v);
    int c0;
    c0 = cyc;
    sw_in = v;
    push(c0 + 6, 3'b000, 3'b000, 3'b000, v, cur_id);
    cur_sw = v;
    tick(8);
  endtask

  initial begin
    logic [19:0] pat;
    logic [3:0]  wrap_ids [8];
    int r;
    wrap_ids = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

    rst = 1'b1;
    tick(3);
    check("rst_key_level", 32'(key_level), 32'h0);
    check("rst_key_press", 32'(key_press), 32'h0);
    check("rst_key_release", 32'(key_release), 32'h0);
    check("rst_sw_level", 32'(sw_level), 32'h0);
    check("rst_peek_id", 32'(peek_id), 32'h0);
    check("rst_peek_address", peek_address, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Clean press/release of KEY0
    pr(3'b001, 4'd1);

    // Key bounce: low runs never exceed 2 cycles
    pat = 20'b1001_0110_1101_0010_1101;
    for (int i = 0; i < 20; i++) begin
      key_n_in = {2'b11, pat[i]};
      tick(1);
    end
    key_n_in = 3'b111;
    tick(8);

    // 3-cycle switch glitch
    sw_in = 10'h020;
    tick(3);
    sw_in = 10'h000;
    tick(8);

    // Wrap tests
    pr(3'b100, 4'd0);
    for (int i = 0; i < 8; i++) pr(3'b001, wrap_ids[i]);
    pr(3'b010, 4'd7);
    pr(3'b010, 4'd6);
    pr(3'b010, 4'd5);
    pr(3'b100, 4'd0);
    pr(3'b001, 4'd1);
    pr(3'b001, 4'd2);
    pr(3'b001, 4'd3);
    pr(3'b011, 4'd3);
    pr(3'b111, 4'd0);

    // Switch level and peek_address
    set_sw(10'h2A5);
    check("peek_address_2A5", peek_address, 32'h0000_02A5);
    check("sw_level_2A5", 32'(sw_level), 32'h2A5);
    set_sw(10'h000);

    // Reset asserted with the KEY0 counter at 2
    key_n_in = 3'b110;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    r = cyc;
    push(r + 6, 3'b001, 3'b001, 3'b000, cur_sw, cur_id);
    push(r + 7, 3'b001, 3'b000, 3'b000, cur_sw, 4'd1);
    cur_id = 4'd1;
    tick(5);
    check("rst_mid_not_yet", 32'(key_level), 32'h0);
    tick(3);
    release_keys(3'b001);

`ifdef BOARD_INPUT_AUTO_REPEAT_EN
    pr(3'b100, 4'd0);
    r = cyc + 6;
    key_n_in = 3'b110;
    push(r,      3'b001, 3'b001, 3'b000, cur_sw, 4'd0);
    push(r + 1,  3'b001, 3'b000, 3'b000, cur_sw, 4'd1);
    push(r + 10, 3'b001, 3'b001, 3'b000, cur_sw, 4'd1);
    push(r + 11, 3'b001, 3'b000, 3'b000, cur_sw, 4'd2);
    push(r + 20, 3'b001, 3'b001, 3'b000, cur_sw, 4'd2);
    push(r + 21, 3'b001, 3'b000, 3'b000, cur_sw, 4'd3);
    push(r + 30, 3'b001, 3'b001, 3'b000, cur_sw, 4'd3);
    push(r + 31, 3'b001, 3'b000, 3'b000, cur_sw, 4'd4);
    cur_id = 4'd4;
    tick(35);
    release_keys(3'b001);
    check("repeat_peek_id", 32'(peek_id), 32'h4);
`endif

    tick(10);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    check("final_peek_address", peek_address, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
